// File: rtl/neuron_pkg.sv
// Shared types and defaults for the neuron accumulator sequencer.
package neuron_pkg;

    localparam int unsigned DefaultLat  = 2;
    localparam int unsigned DefaultMaxN = 64;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Width needed to hold a product count of 0..max_n.
    function automatic int unsigned cnt_width(input int unsigned max_n);
        return $clog2(max_n + 1);
    endfunction

endpackage

// File: rtl/acc_strobe_dly.sv
// Delay line carrying the first/last product flags to the accumulator strobes.
module acc_strobe_dly #(
    parameter int unsigned LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic first_in,
    input  logic last_in,
    output logic first_out,
    output logic last_out
);

    if (LAT == 0) begin : g_wire
        assign first_out = first_in;
        assign last_out  = last_in;
    end else begin : g_pipe
        logic [1:0] dly_q [LAT];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dly_q <= '{default: '0};
            end else if (clr) begin
                dly_q <= '{default: '0};
            end else begin
                dly_q[0] <= {first_in, last_in};
                for (int unsigned i = 1; i < LAT; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign first_out = dly_q[LAT-1][1];
        assign last_out  = dly_q[LAT-1][0];
    end

endmodule

// File: rtl/neuron_acc_seq.sv
// Issues N weight/input reads and strobes the accumulator in step with the multiply pipeline.
module neuron_acc_seq
    import neuron_pkg::*;
#(
    parameter  int unsigned MAX_N  = DefaultMaxN,
    parameter  int unsigned ADDR_W = 8,
    parameter  int unsigned LAT    = DefaultLat,
    localparam int unsigned CNT_W  = cnt_width(MAX_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  n_inputs,
    input  logic [ADDR_W-1:0] mem_base,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              acc_sel,
    output logic              acc_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned DRN_W = (LAT > 1) ? $clog2(LAT) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d, idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DRN_W-1:0]  drn_q, drn_d;
    logic              err_q, err_d;
    logic              idle_like, n_ok, accept, kill, first_flag, last_flag;

    assign idle_like  = (state_q == StIdle) || (state_q == StDone);
    assign n_ok       = (n_inputs != '0) && (n_inputs <= CNT_W'(MAX_N));
    assign accept     = idle_like && start && !abort && n_ok;
    assign kill       = abort && ((state_q == StIssue) || (state_q == StDrain));
    assign first_flag = (state_q == StIssue) && (idx_q == '0);
    assign last_flag  = (state_q == StIssue) && (idx_q == n_q - CNT_W'(1));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        drn_d   = drn_q;
        err_d   = idle_like && start && !abort && !n_ok;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    state_d = StIssue;
                    n_d     = n_inputs;
                    idx_d   = '0;
                    addr_d  = mem_base;
                end
            end
            StIssue: begin
                if (kill) begin
                    state_d = StIdle;
                end else if (last_flag) begin
                    // Address stays on the final read until the next run.
                    state_d = (LAT == 0) ? StDone : StDrain;
                    drn_d   = '0;
                end else begin
                    idx_d  = idx_q + CNT_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            StDrain: begin
                if (kill) begin
                    state_d = StIdle;
                end else if (drn_q == DRN_W'(LAT - 1)) begin
                    state_d = StDone;
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            n_q     <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            drn_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            drn_q   <= drn_d;
            err_q   <= err_d;
        end
    end

    acc_strobe_dly #(
        .LAT(LAT)
    ) u_strobe_dly (
        .clk      (clk),
        .rst      (rst),
        .clr      (kill),
        .first_in (first_flag),
        .last_in  (last_flag),
        .first_out(acc_sel),
        .last_out (acc_en)
    );

    assign mem_addr = addr_q;
    assign mem_rd   = (state_q == StIssue);
    assign busy     = (state_q == StIssue) || (state_q == StDrain);
    assign done     = (state_q == StDone);
    assign err      = err_q;

endmodule

// File: tb/tb_neuron_acc_seq.sv
// Randomised bench for neuron_acc_seq with a cycle-indexed expectation model and accumulator stub.
module tb_neuron_acc_seq;

    localparam int unsigned MAX_N = 64;
    localparam int unsigned LAT   = 2;
    localparam int unsigned CNT_W = 7;
    localparam int unsigned DEPTH = 8192;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] n_inputs = '0;
    logic [7:0]       mem_base = '0;
    logic [7:0]       mem_addr;
    logic             mem_rd, acc_sel, acc_en, busy, done, err;

    neuron_acc_seq #(
        .MAX_N (MAX_N),
        .ADDR_W(8),
        .LAT   (LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .n_inputs(n_inputs),
        .mem_base(mem_base),
        .mem_addr(mem_addr),
        .mem_rd  (mem_rd),
        .acc_sel (acc_sel),
        .acc_en  (acc_en),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wire [13:0] obs = {mem_rd, acc_sel, acc_en, busy, done, err, mem_addr};

    // Memory + multiplier stand-in and the accumulator it feeds.
    logic signed [19:0] prod_mem [256];
    logic signed [7:0]  bias;
    logic signed [19:0] pipe [LAT];
    logic signed [21:0] acc_reg, env_dout, acc_sum;

    assign acc_sum = (acc_sel ? {{14{bias[7]}}, bias} : acc_reg)
                   + {{2{pipe[LAT-1][19]}}, pipe[LAT-1]};

    always @(posedge clk) begin
        pipe[0] <= mem_rd ? prod_mem[mem_addr] : 20'sd0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        acc_reg <= acc_sum;
        if (acc_en) env_dout <= acc_sum;
    end

    // Expected outputs per absolute cycle, painted when a start is accepted.
    bit          e_rd [DEPTH], e_sel [DEPTH], e_en [DEPTH];
    bit          e_busy [DEPTH], e_done [DEPTH], e_err [DEPTH];
    logic [7:0]  e_addr [DEPTH];
    logic [21:0] e_ref [DEPTH];
    int          e_end = 0;
    int          rst_floor = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [13:0] expv(int c);
        logic [7:0] a = 8'h00;
        for (int k = c; k >= rst_floor; k--) begin
            if (e_rd[k]) begin
                a = e_addr[k];
                break;
            end
        end
        return {e_rd[c], e_sel[c], e_en[c], e_busy[c], e_done[c], e_err[c], a};
    endfunction

    function automatic void model_start(int c, int n, logic [7:0] b);
        int s;
        if (c < e_end || abort) return;
        if (n == 0 || n > MAX_N) begin
            e_err[c+1] = 1'b1;
            return;
        end
        s = bias;
        for (int i = 0; i < n; i++) begin
            e_rd[c+1+i]   = 1'b1;
            e_addr[c+1+i] = b + 8'(i);
            s += int'(prod_mem[b + 8'(i)]);
        end
        for (int i = 0; i < n + LAT; i++) e_busy[c+1+i] = 1'b1;
        e_sel[c+1+LAT]    = 1'b1;
        e_en[c+n+LAT]     = 1'b1;
        e_done[c+1+n+LAT] = 1'b1;
        e_ref[c+1+n+LAT]  = 22'(s);
        e_end = c + 1 + n + LAT;
    endfunction

    function automatic void model_abort(int c);
        if (!e_busy[c]) return;
        for (int k = c + 1; k < c + MAX_N + LAT + 3; k++) begin
            e_rd[k] = 0; e_sel[k] = 0; e_en[k] = 0; e_busy[k] = 0; e_done[k] = 0;
        end
        e_end = c + 1;
    endfunction

    function automatic void model_reset(int c);
        for (int k = c; k < c + MAX_N + LAT + 3; k++) begin
            e_rd[k] = 0; e_sel[k] = 0; e_en[k] = 0; e_busy[k] = 0; e_done[k] = 0;
            e_err[k] = 0;
        end
        e_end     = 0;
        rst_floor = c;
    endfunction

    task automatic drive_start(int n, logic [7:0] b);
        start    = 1'b1;
        n_inputs = CNT_W'(n);
        mem_base = b;
        model_start(cyc, n, b);
    endtask

    task automatic drive_abort();
        abort = 1'b1;
        model_abort(cyc);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        start    = 1'b1;
        n_inputs = 7'd4;
        @(negedge clk);
        n_checks++;
        if (obs !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h", obs, 14'h0);
        end
        next_cycle();
        rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL reset_idle j%0d: got %h want %h", j, obs, expv(cyc));
            end
            next_cycle();
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 256; i++) prod_mem[i] = 20'($urandom);
        bias = 8'($urandom);
        for (int j = 0; j < 4 + LAT + 4; j++) begin
            if (j == 0) drive_start(4, 8'h10);
            @(negedge clk);
            n_checks++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL basic c%0d: got %h want %h", j, obs, expv(cyc));
            end
            if (e_done[cyc]) begin
                n_checks++;
                if (env_dout !== e_ref[cyc]) begin
                    n_fail++;
                    $display("FAIL basic_dout: got %h want %h", env_dout, e_ref[cyc]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_single();
        bias           = -8'sd3;
        prod_mem[8'h40] = 20'sd100;
        for (int j = 0; j < 1 + LAT + 4; j++) begin
            if (j == 0) drive_start(1, 8'h40);
            @(negedge clk);
            n_checks++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL single c%0d: got %h want %h", j, obs, expv(cyc));
            end
            if (j == 2 + LAT) begin
                n_checks++;
                if (env_dout !== 22'sd97) begin
                    n_fail++;
                    $display("FAIL single_dout: got %0d want 97", env_dout);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_wrap();
        for (int j = 0; j < 4 + LAT + 4; j++) begin
            if (j == 0) drive_start(4, 8'hFE);
            @(negedge clk);
            n_checks++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL wrap c%0d: got %h want %h", j, obs, expv(cyc));
            end
            if (e_done[cyc]) begin
                n_checks++;
                if (env_dout !== e_ref[cyc]) begin
                    n_fail++;
                    $display("FAIL wrap_dout: got %h want %h", env_dout, e_ref[cyc]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        bias = 8'($urandom);
        for (int j = 0; j < 16; j++) begin
            if (j == 0) drive_start(3, 8'h20);
            if (j == 2) drive_start(5, 8'h90);
            if (j == 4 + LAT) drive_start(2, 8'h80);
            @(negedge clk);
            n_checks++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL b2b c%0d: got %h want %h", j, obs, expv(cyc));
            end
            if (e_done[cyc]) begin
                n_checks++;
                if (env_dout !== e_ref[cyc]) begin
                    n_fail++;
                    $display("FAIL b2b_dout c%0d: got %h want %h", j, env_dout, e_ref[cyc]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reject();
        for (int j = 0; j < 8; j++) begin
            if (j == 0) drive_start(0, 8'h33);
            if (j == 2) drive_start(MAX_N + 1, 8'h33);
            if (j == 4) drive_start(int'($urandom_range(MAX_N + 2, 127)), 8'h44);
            @(negedge clk);
            n_checks++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL reject c%0d: got %h want %h", j, obs, expv(cyc));
            end
            next_cycle();
        end
    endtask

    task automatic test_abort();
        for (int j = 0; j < 26; j++) begin
            if (j == 0)  drive_start(4, 8'h50);
            if (j == 2)  drive_abort();
            if (j == 8)  drive_start(3, 8'h60);
            if (j == 10) begin
                drive_abort();
                drive_start(5, 8'h70);
            end
            if (j == 13) begin
                drive_abort();
                drive_start(2, 8'h78);
            end
            if (j == 15) drive_start(2, 8'hA0);
            if (j == 19) drive_abort();
            @(negedge clk);
            n_checks++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL abort c%0d: got %h want %h", j, obs, expv(cyc));
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 12; j++) begin
            if (j == 0) drive_start(3, 8'hC0);
            if (j == 6) rst = 1'b1;
            if (j == 4) begin
                #2 rst = 1'b0;
                #1;
                model_reset(cyc);
                n_checks++;
                if (obs !== 14'h0) begin
                    n_fail++;
                    $display("FAIL reset_mid_now: got %h want %h", obs, 14'h0);
                end
            end
            @(negedge clk);
            n_checks++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL reset_mid c%0d: got %h want %h", j, obs, expv(cyc));
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 256; i++) prod_mem[i] = 20'($urandom);
        bias = 8'($urandom);
        for (int j = 0; j < 700; j++) begin
            if ($urandom_range(0, 29) == 0) drive_abort();
            if ($urandom_range(0, 3) == 0) begin
                r = int'($urandom_range(0, 15));
                if (r == 0)      drive_start(0, 8'($urandom));
                else if (r == 1) drive_start(int'($urandom_range(MAX_N + 1, 127)), 8'($urandom));
                else             drive_start(int'($urandom_range(1, MAX_N)), 8'($urandom));
            end
            @(negedge clk);
            n_checks++;
            if (obs !== expv(cyc)) begin
                n_fail++;
                $display("FAIL random j%0d: got %h want %h", j, obs, expv(cyc));
            end
            if (e_done[cyc]) begin
                n_checks++;
                if (env_dout !== e_ref[cyc]) begin
                    n_fail++;
                    $display("FAIL random_dout j%0d: got %h want %h", j, env_dout, e_ref[cyc]);
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prod_mem[i] = '0;
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        bias = '0;
        test_reset();
        test_basic();
        test_single();
        test_wrap();
        test_back_to_back();
        test_reject();
        test_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_acc_seq.md
Name: neuron_acc_seq

Overview:
- Sequencer for the neuron accumulator datapath (20-bit product input, 8-bit bias, 22-bit output).
- Issues a run of N weight/input memory reads and drives the accumulator's acc_sel and acc_en strobes, aligned to the multiply pipeline.
- acc_sel loads the bias on the first product; acc_en captures the result on the last product.
- Provides start/busy/done/err handshaking to the layer controller above it.

Parameters:
- MAX_N, 64: maximum products per neuron evaluation.
- ADDR_W, 8: memory address width.
- LAT, 2: cycles from mem_addr issue to the matching product at the accumulator din (memory plus multiplier); LAT >= 0.
- CNT_W, clog2(MAX_N+1): local, width of n_inputs.

Ports:
- clk  in  1  clock; all flops rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled when the FSM is IDLE or DONE.
- abort  in  1  cancels the run in progress.
- n_inputs  in  CNT_W  product count; sampled with start.
- mem_base  in  ADDR_W  first address; sampled with start.
- mem_addr  out  ADDR_W  read address.
- mem_rd  out  1  read strobe.
- acc_sel  out  1  1 = accumulator adds bias instead of accReg.
- acc_en  out  1  accumulator output capture enable.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse; accumulator dout valid.
- err  out  1  one-cycle pulse; start rejected.

Behaviour:
- Reset (rst=0, asynchronous): FSM in IDLE, delay lines cleared. All outputs are 0, including mem_addr.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- Start accept:
  - start is accepted in IDLE or DONE when 1 <= n_inputs <= MAX_N and abort=0.
  - On accept, latch N = n_inputs and base = mem_base, then go to ISSUE.
  - start in ISSUE or DRAIN is ignored, with no err.
- Start reject: start in IDLE or DONE with n_inputs == 0 or n_inputs > MAX_N pulses err the next cycle and leaves the state unchanged (DONE goes to IDLE as normal).
- Timing, taking c0 as the start cycle and c1 = c0+1:
  - ISSUE lasts N cycles, c1 .. c1+N-1.
  - mem_rd=1 throughout ISSUE; mem_addr = base+i in cycle c1+i.
  - Address addition wraps modulo 2^ADDR_W.
  - DRAIN lasts LAT cycles, c1+N .. c1+N+LAT-1, with mem_rd=0. When LAT=0, ISSUE goes directly to DONE.
  - acc_sel=1 only in cycle c1+LAT, the first product.
  - acc_en=1 only in cycle c1+N-1+LAT, the last product. For N=1 both strobes fall in the same cycle.
  - DONE lasts exactly 1 cycle, c1+N+LAT, with done=1. It then goes to IDLE unless a valid start arrives in that cycle, in which case it goes to ISSUE back-to-back.
- busy=1 in ISSUE and DRAIN only.
- acc_sel and acc_en come from a LAT-deep delay line:
  - The delay line is fed a "first" flag (ISSUE with i==0) and a "last" flag (ISSUE with i==N-1).
  - Both strobes are driven directly from flops.
- mem_addr holds its last value outside ISSUE.
- abort:
  - In ISSUE or DRAIN, abort moves the FSM to IDLE next cycle and clears the delay lines.
  - No acc_sel, acc_en or done follows an abort.
  - If abort and start arrive in the same cycle, abort wins and start is ignored.
  - In IDLE or DONE, abort has no effect other than suppressing start.
- Reset asserted mid-run: immediate return to the reset state; no strobes follow.

Decomposition:
- Package neuron_pkg holds:
  - the state encoding (IDLE=0, ISSUE=1, DRAIN=2, DONE=3);
  - default LAT and MAX_N;
  - the CNT_W helper function.
- Sub-module acc_strobe_dly: LAT-stage shift register of width 2 (first, last).
  - It has a synchronous clear input used by abort.
  - Resets asynchronously to 0.
  - When LAT=0 it is a wire.

Test Plan:
- LAT=2, N=4, base=0x10, start at c0:
  - mem_addr 0x10..0x13 with mem_rd=1 in c1..c4.
  - acc_sel in c3; acc_en in c6; done in c7; busy c1..c6.
- N=1:
  - acc_sel and acc_en both in c1+LAT.
  - Accumulator output = bias + single product (e.g. bias=-3, product=100 -> dout=97).
- base=0xFE, N=4:
  - mem_addr sequence 0xFE, 0xFF, 0x00, 0x01.
- Back-to-back:
  - Second start in the done cycle gives mem_rd=1 with no gap and a correct second acc_sel.
  - start during busy is ignored, with no err.
- n_inputs=0, then n_inputs=MAX_N+1:
  - err pulse each time; busy stays 0; no mem_rd.
- abort in the second ISSUE cycle:
  - IDLE next cycle; no acc_sel or acc_en, even if the first-flag is in flight.
  - No done.
  - Repeat with rst pulsed low mid-DRAIN: all outputs 0 immediately.
